// File: rtl/systolic_feeder.sv
// systolic_feeder
// Drives the west (A) and north (B) edges of an N x N output-stationary
// systolic array. One A column / B row is accepted per beat. Lane i is
// delayed by i extra cycles so PE(i,j) sees A[i][k] and B[k][j] together.
// A per-anti-diagonal clear pulse travels with the first beat of each
// tile. Once the last beat has drained through the array, tile_done is
// raised and held until the collector acknowledges.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     upstream beat valid
//   in_ready     feeder can accept a beat (transfer = in_valid && in_ready)
//   in_a, in_b   A column / B row, lane i at [i*WIDTH +: WIDTH]
//   in_last      final beat of the tile (meaningful only on a transfer)
//   a_edge       skewed A lanes to PE(i,0).a_in
//   b_edge       skewed B lanes to PE(0,j).b_in
//   clear_diag   PE(i,j).clear = clear_diag[i+j]
//   busy         tile in progress (STREAM, FLUSH, DONE)
//   tile_done    all c_out final; held until result_ack
//   result_ack   collector has captured the results
module systolic_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_a,
    input  logic [N*WIDTH-1:0]   in_b,
    input  logic                 in_last,
    output logic [N*WIDTH-1:0]   a_edge,
    output logic [N*WIDTH-1:0]   b_edge,
    output logic [2*N-2:0]       clear_diag,
    output logic                 busy,
    output logic                 tile_done,
    input  logic                 result_ack
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    localparam int               CNT_W      = $clog2(2*N);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2*N-2);

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic             xfer;
    logic             first_beat;
    logic [2*N-2:0]   clr_p;

    // A stalled or refused cycle feeds zeros so the PEs accumulate nothing.
    function automatic logic [WIDTH-1:0] lane_or_bubble(
        input logic [N*WIDTH-1:0] bus,
        input int                 lane,
        input logic               take
    );
        return take ? bus[lane*WIDTH +: WIDTH] : '0;
    endfunction

    // in_ready is forced low combinationally while rst is asserted.
    assign in_ready   = !rst && (state == IDLE || state == STREAM);
    assign xfer       = in_valid && in_ready;
    assign first_beat = xfer && (state == IDLE);

    // Stage p0..pi: lane i is delayed through i+1 registers.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [WIDTH-1:0] a_p [0:i];
        logic signed [WIDTH-1:0] b_p [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    a_p[s] <= '0;
                    b_p[s] <= '0;
                end
            end else begin
                a_p[0] <= lane_or_bubble(in_a, i, xfer);
                b_p[0] <= lane_or_bubble(in_b, i, xfer);
                for (int s = 1; s <= i; s++) begin
                    a_p[s] <= a_p[s-1];
                    b_p[s] <= b_p[s-1];
                end
            end
        end

        assign a_edge[i*WIDTH +: WIDTH] = a_p[i];
        assign b_edge[i*WIDTH +: WIDTH] = b_p[i];
    end

    // Clear pulse travels one anti-diagonal per cycle alongside beat 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_p <= '0;
        end else begin
            clr_p[0] <= first_beat;
            for (int d = 1; d <= 2*N-2; d++) begin
                clr_p[d] <= clr_p[d-1];
            end
        end
    end

    assign clear_diag = clr_p;

    // Tile sequencing. FLUSH spans 2N-1 edges after the last beat so the
    // final beat reaches PE(N-1,N-1) and is sampled before DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (xfer && in_last) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state     <= DONE;
                        tile_done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state     <= IDLE;
                        tile_done <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
